ps2_mouse_device_sm: RTL and testbench

//  Device-side PS/2 mouse responder: the far end of the host mouse master SM. Sits between a

---
 rtl/ps2_mouse_device_sm.sv | 200 ++++++++++++++++++++
 tb/tb_ps2_mouse_device_sm.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_device_sm.sv
// Device-side PS/2 mouse responder: answers host commands and streams
// 3-byte movement packets built from saturating signed accumulators.
module ps2_mouse_device_sm #(
    parameter int POWERUP_DELAY = 1000,
    parameter int SAMPLE_PERIOD = 50000,
    parameter int TX_TIMEOUT    = 500000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BYTE_RX_READY,
    input  logic [7:0] BYTE_RX,
    input  logic       BYTE_RX_ERROR,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    input  logic       MOVE_VALID,
    input  logic [8:0] MOVE_DX,
    input  logic [8:0] MOVE_DY,
    input  logic [2:0] BUTTONS,
    output logic       STREAMING,
    output logic [3:0] CURRENT_STATE
);

    typedef enum logic [3:0] {
        S_POWERUP  = 4'd0,
        S_WAIT_AA  = 4'd1,
        S_WAIT_ID  = 4'd2,
        S_IDLE     = 4'd3,
        S_WAIT_RSP = 4'd4,
        S_WAIT_ST  = 4'd5,
        S_WAIT_DX  = 4'd6,
        S_WAIT_DY  = 4'd7
    } state_t;

    typedef enum logic [1:0] {P_NONE, P_RESET, P_ID} pend_t;

    localparam int TMAX = (POWERUP_DELAY > TX_TIMEOUT) ? POWERUP_DELAY : TX_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int SW   = $clog2(SAMPLE_PERIOD + 1);

    state_t             state, state_n;
    pend_t              pend, pend_n;
    logic [TW-1:0]      tmr;
    logic [SW-1:0]      samp;
    logic               pkt_seen;
    logic               rx_v, rx_e;
    logic [7:0]         rx_b;
    logic signed [9:0]  acc_x, acc_y, acc_x_n, acc_y_n;
    logic               ovf_x, ovf_y, ovf_x_n, ovf_y_n;
    logic [2:0]         last_btn;
    logic [7:0]         pkt_dx, pkt_dy;
    logic               send_n, stream_n;
    logic [7:0]         byte_n;
    logic               clr_acc, latch_pkt, take_cmd;
    logic               cmd_v, cmd_e;
    logic [7:0]         cmd_b;
    logic               tmo, pu_done, samp_exp, report;

    // A live byte takes precedence over an older latched one.
    assign cmd_v    = BYTE_RX_READY | rx_v;
    assign cmd_e    = BYTE_RX_READY ? BYTE_RX_ERROR : rx_e;
    assign cmd_b    = BYTE_RX_READY ? BYTE_RX : rx_b;
    assign tmo      = (tmr == TW'(TX_TIMEOUT - 1));
    assign pu_done  = (tmr == TW'(POWERUP_DELAY - 1));
    assign samp_exp = (samp == SW'(SAMPLE_PERIOD)) | ~pkt_seen;
    assign report   = (acc_x != '0) | (acc_y != '0) | ovf_x | ovf_y
                    | (BUTTONS != last_btn);
    assign CURRENT_STATE = state;

    function automatic logic signed [9:0] sat(input logic signed [9:0] v);
        if (v > 10'sd255)
            return 10'sd255;
        else if (v < -10'sd256)
            return -10'sd256;
        return v;
    endfunction

    always_comb begin
        state_n   = state;
        pend_n    = pend;
        send_n    = 1'b0;
        byte_n    = BYTE_TO_SEND;
        stream_n  = STREAMING;
        clr_acc   = 1'b0;
        latch_pkt = 1'b0;
        take_cmd  = 1'b0;
        unique case (state)
            S_POWERUP: if (pu_done) begin
                send_n = 1'b1; byte_n = 8'hAA; state_n = S_WAIT_AA;
            end
            S_WAIT_AA: if (BYTE_SENT) begin
                send_n = 1'b1; byte_n = 8'h00; state_n = S_WAIT_ID;
            end else if (tmo) state_n = S_IDLE;
            S_WAIT_ID: if (BYTE_SENT | tmo) state_n = S_IDLE;
            S_IDLE: if (cmd_v) begin
                take_cmd = 1'b1;
                send_n   = 1'b1;
                byte_n   = 8'hFA;
                pend_n   = P_NONE;
                state_n  = S_WAIT_RSP;
                if (cmd_e) byte_n = 8'hFE;
                else begin
                    case (cmd_b)
                        8'hFF: begin stream_n = 1'b0; clr_acc = 1'b1; pend_n = P_RESET; end
                        8'hF4: stream_n = 1'b1;
                        8'hF5: stream_n = 1'b0;
                        8'hF2: pend_n = P_ID;
                        default: byte_n = 8'hFE;
                    endcase
                end
            end else if (STREAMING && samp_exp && report) begin
                latch_pkt = 1'b1;
                send_n    = 1'b1;
                byte_n    = {ovf_y, ovf_x, acc_y[8], acc_x[8], 1'b1, BUTTONS};
                state_n   = S_WAIT_ST;
            end
            S_WAIT_RSP: if (BYTE_SENT) begin
                pend_n = P_NONE;
                case (pend)
                    P_RESET: state_n = S_POWERUP;
                    P_ID:    begin send_n = 1'b1; byte_n = 8'h00; state_n = S_WAIT_ID; end
                    default: state_n = S_IDLE;
                endcase
            end else if (tmo) begin
                pend_n = P_NONE; state_n = S_IDLE;
            end
            // A pending host byte abandons the rest of the packet.
            S_WAIT_ST: if (BYTE_SENT && !cmd_v) begin
                send_n = 1'b1; byte_n = pkt_dx; state_n = S_WAIT_DX;
            end else if (BYTE_SENT | tmo) state_n = S_IDLE;
            S_WAIT_DX: if (BYTE_SENT && !cmd_v) begin
                send_n = 1'b1; byte_n = pkt_dy; state_n = S_WAIT_DY;
            end else if (BYTE_SENT | tmo) state_n = S_IDLE;
            S_WAIT_DY: if (BYTE_SENT | tmo) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        logic signed [9:0] bx, by, sx, sy;
        bx = (clr_acc | latch_pkt) ? 10'sd0 : acc_x;
        by = (clr_acc | latch_pkt) ? 10'sd0 : acc_y;
        sx = bx + $signed({MOVE_DX[8], MOVE_DX});
        sy = by + $signed({MOVE_DY[8], MOVE_DY});
        acc_x_n = MOVE_VALID ? sat(sx) : bx;
        acc_y_n = MOVE_VALID ? sat(sy) : by;
        ovf_x_n = (~(clr_acc | latch_pkt) & ovf_x) | (MOVE_VALID & (sat(sx) != sx));
        ovf_y_n = (~(clr_acc | latch_pkt) & ovf_y) | (MOVE_VALID & (sat(sy) != sy));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= S_POWERUP;
            pend         <= P_NONE;
            tmr          <= '0;
            samp         <= '0;
            pkt_seen     <= 1'b0;
            rx_v         <= 1'b0;
            rx_e         <= 1'b0;
            rx_b         <= '0;
            acc_x        <= '0;
            acc_y        <= '0;
            ovf_x        <= 1'b0;
            ovf_y        <= 1'b0;
            last_btn     <= '0;
            pkt_dx       <= '0;
            pkt_dy       <= '0;
            SEND_BYTE    <= 1'b0;
            BYTE_TO_SEND <= '0;
            STREAMING    <= 1'b0;
        end else begin
            state        <= state_n;
            pend         <= pend_n;
            tmr          <= (state_n != state) ? '0 : tmr + 1'b1;
            SEND_BYTE    <= send_n;
            BYTE_TO_SEND <= byte_n;
            STREAMING    <= stream_n;
            acc_x        <= acc_x_n;
            acc_y        <= acc_y_n;
            ovf_x        <= ovf_x_n;
            ovf_y        <= ovf_y_n;
            if (take_cmd) rx_v <= 1'b0;
            else if (BYTE_RX_READY) begin
                rx_v <= 1'b1;
                rx_e <= BYTE_RX_ERROR;
                rx_b <= BYTE_RX;
            end
            if (latch_pkt) begin
                samp     <= '0;
                pkt_seen <= 1'b1;
                last_btn <= BUTTONS;
                pkt_dx   <= acc_x[7:0];
                pkt_dy   <= acc_y[7:0];
            end else if (samp != SW'(SAMPLE_PERIOD)) begin
                samp <= samp + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_device_sm.sv
// Bench for ps2_mouse_device_sm: a byte sink acknowledges every sent
// byte after 20 cycles; command vectors run from a table.
module tb_ps2_mouse_device_sm;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       BYTE_RX_READY = 1'b0;
    logic [7:0] BYTE_RX = '0;
    logic       BYTE_RX_ERROR = 1'b0;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT = 1'b0;
    logic       MOVE_VALID = 1'b0;
    logic [8:0] MOVE_DX = '0;
    logic [8:0] MOVE_DY = '0;
    logic [2:0] BUTTONS = '0;
    logic       STREAMING;
    logic [3:0] CURRENT_STATE;

    ps2_mouse_device_sm #(
        .POWERUP_DELAY(30),
        .SAMPLE_PERIOD(100),
        .TX_TIMEOUT(60)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .BYTE_RX_READY(BYTE_RX_READY), .BYTE_RX(BYTE_RX),
        .BYTE_RX_ERROR(BYTE_RX_ERROR),
        .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND),
        .BYTE_SENT(BYTE_SENT),
        .MOVE_VALID(MOVE_VALID), .MOVE_DX(MOVE_DX), .MOVE_DY(MOVE_DY),
        .BUTTONS(BUTTONS),
        .STREAMING(STREAMING), .CURRENT_STATE(CURRENT_STATE)
    );

    always #5 CLK = ~CLK;

    logic [7:0] txq[$];
    int         cnt = 0;
    logic       ack_en = 1'b1;
    int         tests = 0;
    int         fails = 0;

    // Byte sink: records each SEND_BYTE and acks it 20 cycles later.
    always @(negedge CLK) begin
        BYTE_SENT = 1'b0;
        if (RESET) cnt = 0;
        else if (SEND_BYTE) begin
            txq.push_back(BYTE_TO_SEND);
            cnt = 20;
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0 && ack_en) BYTE_SENT = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_byte(input string name, input logic [7:0] exp);
        int t = 0;
        while (txq.size() == 0 && t < 500) begin
            @(negedge CLK);
            t++;
        end
        if (txq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: no byte within budget, expected %02h", name, exp);
        end else begin
            chk(name, {24'd0, txq.pop_front()}, {24'd0, exp});
        end
    endtask

    task automatic host(input logic [7:0] b, input logic err);
        @(negedge CLK);
        BYTE_RX_READY = 1'b1;
        BYTE_RX = b;
        BYTE_RX_ERROR = err;
        @(negedge CLK);
        BYTE_RX_READY = 1'b0;
        BYTE_RX_ERROR = 1'b0;
    endtask

    task automatic move(input logic [8:0] dx, input logic [8:0] dy);
        @(negedge CLK);
        MOVE_VALID = 1'b1;
        MOVE_DX = dx;
        MOVE_DY = dy;
        @(negedge CLK);
        MOVE_VALID = 1'b0;
    endtask

    task automatic settle(input string name, input logic stream);
        repeat (25) @(negedge CLK);
        chk({name, "_state"}, {28'd0, CURRENT_STATE}, 32'd3);
        chk({name, "_stream"}, {31'd0, STREAMING}, {31'd0, stream});
        chk({name, "_extra"}, txq.size(), 0);
    endtask

    typedef struct {
        string       name;
        logic [7:0]  cmd;
        logic        err;
        int          n;
        logic [23:0] rsp;
        logic        stream;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"ff_reset", 8'hFF, 1'b0, 3, 24'hFA_AA_00, 1'b0};
        vecs[1] = '{"bad_e8",   8'hE8, 1'b0, 1, 24'hFE_00_00, 1'b0};
        vecs[2] = '{"rx_err",   8'hF4, 1'b1, 1, 24'hFE_00_00, 1'b0};
        vecs[3] = '{"get_id",   8'hF2, 1'b0, 2, 24'hFA_00_00, 1'b0};
        vecs[4] = '{"enable",   8'hF4, 1'b0, 1, 24'hFA_00_00, 1'b1};
        vecs[5] = '{"disable",  8'hF5, 1'b0, 1, 24'hFA_00_00, 1'b0};

        repeat (3) @(negedge CLK);
        chk("rst_send", {31'd0, SEND_BYTE}, 32'd0);
        chk("rst_byte", {24'd0, BYTE_TO_SEND}, 32'd0);
        chk("rst_stream", {31'd0, STREAMING}, 32'd0);
        chk("rst_state", {28'd0, CURRENT_STATE}, 32'd0);
        RESET = 1'b0;
        expect_byte("boot_aa", 8'hAA);
        expect_byte("boot_id", 8'h00);
        settle("boot", 1'b0);

        for (int i = 0; i < 6; i++) begin
            host(vecs[i].cmd, vecs[i].err);
            for (int k = 0; k < vecs[i].n; k++)
                expect_byte(vecs[i].name, vecs[i].rsp[8*(2-k) +: 8]);
            settle(vecs[i].name, vecs[i].stream);
        end

        // Movement and buttons staged while the F4 ack is in flight.
        host(8'hF4, 1'b0);
        expect_byte("pk1_ack", 8'hFA);
        BUTTONS = 3'b001;
        move(9'd5, 9'h1FD);
        expect_byte("pk1_st", 8'h29);
        expect_byte("pk1_dx", 8'h05);
        BUTTONS = 3'b000;
        move(9'd200, 9'd0);
        move(9'd200, 9'd0);
        expect_byte("pk1_dy", 8'hFD);
        expect_byte("pk2_st", 8'h48);
        expect_byte("pk2_dx", 8'hFF);
        expect_byte("pk2_dy", 8'h00);
        chk("pk2_stream", {31'd0, STREAMING}, 32'd1);

        // F5 during DX byte cuts the packet short.
        move(9'd1, 9'd0);
        expect_byte("pk3_st", 8'h08);
        expect_byte("pk3_dx", 8'h01);
        host(8'hF5, 1'b0);
        expect_byte("abort_fa", 8'hFA);
        settle("abort", 1'b0);

        // No ack: transmit timeout returns to IDLE.
        ack_en = 1'b0;
        host(8'hE8, 1'b0);
        expect_byte("tmo_fe", 8'hFE);
        repeat (70) @(negedge CLK);
        chk("tmo_state", {28'd0, CURRENT_STATE}, 32'd3);
        chk("tmo_extra", txq.size(), 0);
        ack_en = 1'b1;

        // Reset while the F2 ack is still outstanding.
        host(8'hF2, 1'b0);
        expect_byte("mid_fa", 8'hFA);
        repeat (5) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        chk("mid_state", {28'd0, CURRENT_STATE}, 32'd0);
        chk("mid_send", {31'd0, SEND_BYTE}, 32'd0);
        chk("mid_byte", {24'd0, BYTE_TO_SEND}, 32'd0);
        RESET = 1'b0;
        expect_byte("mid_aa", 8'hAA);
        expect_byte("mid_id", 8'h00);
        settle("mid", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
